// File: rtl/drc_cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// drc_cache_ctrl_if
// Request/response handshake bundle between a requester and drc_cache_ctrl.
//   req_*  : one LOOKUP (req_op=0) or INSERT (req_op=1) request, valid/ready
//   rsp_*  : result of the request, valid/ready
// master : the requester side (drives req_*, rsp_ready)
// slave  : the controller side (drives req_ready, rsp_*)
// N_WAY must match the N_WAY of the attached controller.
// -----------------------------------------------------------------------------
interface drc_cache_ctrl_if #(
  parameter int N_WAY = 4
);
  localparam int WAY_WIDTH = $clog2(N_WAY);

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_op;
  logic [23:0]          req_addr;
  logic [1:0]           req_type;
  logic [31:0]          req_syn;
  logic [271:0]         req_data;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [WAY_WIDTH-1:0] rsp_way;
  logic [1:0]           rsp_type;
  logic [31:0]          rsp_syn;
  logic [14:0]          rsp_cnt;
  logic [271:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_type, req_syn, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_type, rsp_syn, rsp_cnt,
           rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_type, req_syn, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_type, rsp_syn, rsp_cnt,
           rsp_data
  );
endinterface

// File: rtl/drc_cache_ctrl.sv
// -----------------------------------------------------------------------------
// drc_cache_ctrl
// Sequencing controller for the DRC set-associative cache SRAM.
// Takes one LOOKUP/INSERT request at a time, reads the indexed set, compares
// tags across all ways, picks the way to write (hit way / first invalid way /
// least-count way), issues the SRAM write and returns a response.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request/response handshake (drc_cache_ctrl_if)
//   rden, raddr       SRAM read port, data returns one cycle later
//   rdata_*           per-way read data, way w at slice w
//   wren, waddr,      SRAM write port (wdata_line selects the way)
//   wdata_line,
//   wdata_*
//   hit_count,        saturating LOOKUP hit / miss statistics
//   miss_count
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready for a request; latch it on req_valid
// S_READ  | rden for the latched set index
// S_CMP   | read data valid: tag compare, way selection, statistics
// S_WRITE | wren for the selected way
// S_RESP  | response held until rsp_ready
// -----------------------------------------------------------------------------
module drc_cache_ctrl #(
  parameter  int N_ENTRY   = 64,
  parameter  int N_WAY     = 4,
  localparam int ADDR_SIZE = 24,
  localparam int IDX_SIZE  = $clog2(N_ENTRY / N_WAY),
  localparam int TAG_SIZE  = ADDR_SIZE - IDX_SIZE,
  localparam int WAY_WIDTH = $clog2(N_WAY)
) (
  input  logic                      clk,
  input  logic                      rst_n,

  drc_cache_ctrl_if.slave           bus,

  output logic                      rden,
  output logic [IDX_SIZE-1:0]       raddr,
  input  logic [N_WAY-1:0]          rdata_valid,
  input  logic [N_WAY*2-1:0]        rdata_type,
  input  logic [N_WAY*32-1:0]       rdata_syn,
  input  logic [N_WAY*TAG_SIZE-1:0] rdata_tag,
  input  logic [N_WAY*15-1:0]       rdata_cnt,
  input  logic [N_WAY*272-1:0]      rdata_data,

  output logic                      wren,
  output logic [IDX_SIZE-1:0]       waddr,
  output logic [WAY_WIDTH-1:0]      wdata_line,
  output logic [1:0]                wdata_type,
  output logic [31:0]               wdata_syn,
  output logic [TAG_SIZE-1:0]       wdata_tag,
  output logic [14:0]               wdata_cnt,
  output logic [271:0]              wdata_data,

  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
);

  localparam logic OP_LOOKUP = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CMP,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // Ready is a flop rather than a decode of S_IDLE so that it reads 0 while
  // reset is asserted and rises on the first clock after release.
  logic                 rdy_q, rdy_d;

  logic                 op_q, op_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [1:0]           type_q, type_d;
  logic [31:0]          syn_q, syn_d;
  logic [271:0]         data_q, data_d;

  logic                 rsp_hit_q, rsp_hit_d;
  logic [WAY_WIDTH-1:0] rsp_way_q, rsp_way_d;
  logic [1:0]           rsp_type_q, rsp_type_d;
  logic [31:0]          rsp_syn_q, rsp_syn_d;
  logic [14:0]          rsp_cnt_q, rsp_cnt_d;
  logic [271:0]         rsp_data_q, rsp_data_d;

  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;

  logic [IDX_SIZE-1:0]  req_idx;
  logic [TAG_SIZE-1:0]  req_tag;

  assign req_idx = addr_q[IDX_SIZE-1:0];
  assign req_tag = addr_q[ADDR_SIZE-1:IDX_SIZE];

  // ---------------------------------------------------------------------------
  // Tag compare and way selection on the returned set
  // ---------------------------------------------------------------------------
  logic [N_WAY-1:0]     hit_vec;
  logic                 hit_any;
  logic [WAY_WIDTH-1:0] hit_way;
  logic                 inv_any;
  logic [WAY_WIDTH-1:0] inv_way;
  logic [WAY_WIDTH-1:0] min_way;
  logic [14:0]          min_cnt;
  logic [WAY_WIDTH-1:0] victim_way;

  always_comb begin
    hit_vec = '0;
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    min_way = '0;
    min_cnt = rdata_cnt[14:0];

    for (int w = 0; w < N_WAY; w++) begin
      hit_vec[w] = rdata_valid[w] &&
                   (rdata_tag[w*TAG_SIZE +: TAG_SIZE] == req_tag);
    end

    // Walk from the top so the lowest matching / invalid way is kept.
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
      if (!rdata_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_WIDTH'(w);
      end
    end

    // Strict less-than keeps the lowest index on equal counts.
    for (int w = 1; w < N_WAY; w++) begin
      if (rdata_cnt[w*15 +: 15] < min_cnt) begin
        min_cnt = rdata_cnt[w*15 +: 15];
        min_way = WAY_WIDTH'(w);
      end
    end

    if (hit_any) begin
      victim_way = hit_way;
    end else if (inv_any) begin
      victim_way = inv_way;
    end else begin
      victim_way = min_way;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, request capture, response capture, statistics
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    type_d     = type_q;
    syn_d      = syn_q;
    data_d     = data_q;
    rsp_hit_d  = rsp_hit_q;
    rsp_way_d  = rsp_way_q;
    rsp_type_d = rsp_type_q;
    rsp_syn_d  = rsp_syn_q;
    rsp_cnt_d  = rsp_cnt_q;
    rsp_data_d = rsp_data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rden       = 1'b0;
    wren       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && rdy_q) begin
          op_d       = bus.req_op;
          addr_d     = bus.req_addr;
          type_d     = bus.req_type;
          syn_d      = bus.req_syn;
          data_d     = bus.req_data;
          rsp_hit_d  = 1'b0;
          rsp_way_d  = '0;
          rsp_type_d = '0;
          rsp_syn_d  = '0;
          rsp_cnt_d  = '0;
          rsp_data_d = '0;
          state_d    = S_READ;
        end
      end

      S_READ: begin
        rden    = 1'b1;
        state_d = S_CMP;
      end

      S_CMP: begin
        if (op_q == OP_LOOKUP) begin
          if (hit_any) begin
            rsp_hit_d  = 1'b1;
            rsp_way_d  = hit_way;
            rsp_type_d = rdata_type[hit_way*2 +: 2];
            rsp_syn_d  = rdata_syn[hit_way*32 +: 32];
            rsp_cnt_d  = rdata_cnt[hit_way*15 +: 15];
            rsp_data_d = rdata_data[hit_way*272 +: 272];
            if (hit_cnt_q != 32'hFFFF_FFFF) begin
              hit_cnt_d = hit_cnt_q + 32'd1;
            end
            state_d = S_WRITE;
          end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) begin
              miss_cnt_d = miss_cnt_q + 32'd1;
            end
            state_d = S_RESP;
          end
        end else begin
          // INSERT reports whether the tag was already present; no payload.
          rsp_hit_d = hit_any;
          rsp_way_d = victim_way;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        wren    = 1'b1;
        state_d = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d = (state_d == S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // SRAM port data. A LOOKUP hit rewrites the captured line with cnt+1
  // (saturating); an INSERT writes the request payload with cnt=0. All data
  // lines are forced to 0 outside their strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    raddr      = '0;
    waddr      = '0;
    wdata_line = '0;
    wdata_type = '0;
    wdata_syn  = '0;
    wdata_tag  = '0;
    wdata_cnt  = '0;
    wdata_data = '0;

    if (rden) begin
      raddr = req_idx;
    end

    if (wren) begin
      waddr      = req_idx;
      wdata_line = rsp_way_q;
      wdata_tag  = req_tag;
      if (op_q == OP_LOOKUP) begin
        wdata_type = rsp_type_q;
        wdata_syn  = rsp_syn_q;
        wdata_data = rsp_data_q;
        wdata_cnt  = (rsp_cnt_q == 15'h7FFF) ? rsp_cnt_q : rsp_cnt_q + 15'd1;
      end else begin
        wdata_type = type_q;
        wdata_syn  = syn_q;
        wdata_data = data_q;
        wdata_cnt  = '0;
      end
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_way   = rsp_way_q;
  assign bus.rsp_type  = rsp_type_q;
  assign bus.rsp_syn   = rsp_syn_q;
  assign bus.rsp_cnt   = rsp_cnt_q;
  assign bus.rsp_data  = rsp_data_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      op_q       <= 1'b0;
      addr_q     <= '0;
      type_q     <= '0;
      syn_q      <= '0;
      data_q     <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_way_q  <= '0;
      rsp_type_q <= '0;
      rsp_syn_q  <= '0;
      rsp_cnt_q  <= '0;
      rsp_data_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      type_q     <= type_d;
      syn_q      <= syn_d;
      data_q     <= data_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_way_q  <= rsp_way_d;
      rsp_type_q <= rsp_type_d;
      rsp_syn_q  <= rsp_syn_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rsp_data_q <= rsp_data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: doc/drc_cache_ctrl.md
Name: drc_cache_ctrl

Overview:
- Sequencing controller for the DRC set-associative cache SRAM: N_WAY ways, N_ENTRY lines, 1-cycle read latency, per-way valid/type/syn/tag/cnt/data fields.
- Accepts one lookup or insert request at a time and issues the SRAM read.
- Performs the tag compare across all ways, selects the victim on insert, and issues the SRAM write.
- Returns a response through a valid/ready handshake and keeps hit/miss statistics.

Parameters:
- N_ENTRY, 64, total cache lines.
- N_WAY, 4, associativity.
- Derived (localparam, not overridable): ADDR_SIZE=24, IDX_SIZE=$clog2(N_ENTRY/N_WAY), TAG_SIZE=ADDR_SIZE-IDX_SIZE, WAY_WIDTH=$clog2(N_WAY).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_op  in  1  0=LOOKUP, 1=INSERT
- req_addr  in  24  [IDX_SIZE-1:0]=set index, [23:IDX_SIZE]=tag
- req_type/req_syn/req_data  in  2/32/272  INSERT payload
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_hit  out  1  tag matched a valid way
- rsp_way  out  WAY_WIDTH  hit way (LOOKUP hit) or written way (INSERT)
- rsp_type/rsp_syn/rsp_cnt/rsp_data  out  2/32/15/272  hit line contents (LOOKUP hit), else 0
- rden, raddr  out  1, IDX_SIZE  SRAM read port
- rdata_valid  in  N_WAY  per-way valid, bit w = way w
- rdata_type/syn/tag/cnt/data  in  N_WAY×(2/32/TAG_SIZE/15/272), packed, way w at slice w
- wren, waddr, wdata_line  out  1, IDX_SIZE, WAY_WIDTH  SRAM write port
- wdata_type/syn/tag/cnt/data  out  2/32/TAG_SIZE/15/272
- hit_count, miss_count  out  32, 32  saturating statistics

Behaviour:
- FSM states: IDLE, READ, CMP, WRITE, RESP.
- Reset: all outputs 0, state IDLE, request registers 0, statistics 0.
- IDLE: req_ready=1. On req_valid, latch op/addr/payload and go to READ. req_ready=0 in all other states; only one request is outstanding.
- READ (T+1): rden=1, raddr=latched index, for exactly one cycle.
- CMP (T+2): rdata is valid this cycle. hit_vec[w] = rdata_valid[w] && rdata_tag[w]==latched tag. On multiple matches, the lowest-index way wins. Matched line fields are registered.
- LOOKUP hit:
  - Go to WRITE. Write the hit way with the same type/syn/tag/data and cnt+1, saturating at 15'h7FFF.
  - rsp_cnt returns the pre-increment value.
  - hit_count+1.
- LOOKUP miss: go directly to RESP. rsp_hit=0, rsp_way=0, payload fields 0. miss_count+1.
- INSERT way selection:
  - Hit: overwrite the hit way, rsp_hit=1.
  - Miss with an invalid way: use the lowest-index invalid way, rsp_hit=0.
  - Miss, all ways valid: victim is the way with minimum cnt; ties go to the lowest index.
  - The written line gets cnt=0 and req type/syn/data. The SRAM marks written lines valid.
  - INSERT does not change the statistics.
- WRITE (T+3): wren=1 for one cycle with waddr/wdata_line/wdata_*. Then RESP.
- RESP: rsp_valid=1 and rsp_* held stable until rsp_ready. On rsp_ready go to IDLE; the next request is accepted no earlier than the following cycle.
- Latency from acceptance edge to rsp_valid: 3 cycles for LOOKUP miss, 4 cycles for LOOKUP hit and INSERT.
- rden, wren and rsp_valid are never asserted in IDLE. rden and wren are never asserted in the same cycle.
- Statistics counters saturate at 32'hFFFF_FFFF.
- rst_n low in any state: immediate return to IDLE, rden/wren/rsp_valid drop to 0, in-flight request discarded, no write issued.

Test Plan:
- Defaults (16 sets, TAG_SIZE=20); all ways invalid. LOOKUP 0x123456 -> rden at T+1 with raddr=6; rsp_valid at T+3 with rsp_hit=0; miss_count=1; no wren.
- INSERT 0x123456, type=2, syn=0xDEADBEEF -> wren at T+3, waddr=6, wdata_line=0, wdata_tag=0x12345, wdata_cnt=0; rsp_hit=0, rsp_way=0.
- Way 2 of set 6 valid with tag 0x12345 and cnt=5. LOOKUP 0x123456 -> rsp_hit=1, rsp_way=2, rsp_cnt=5; write to way 2 with cnt=6; hit_count=1.
- Set 3 full with cnt={9,4,4,7}. INSERT a new tag at index 3 -> wdata_line=1 (tie broken to lowest index), wdata_cnt=0.
- Hit with cnt=0x7FFF -> written cnt stays 0x7FFF. rsp_ready held low 5 cycles -> rsp_* stable and req_ready=0 throughout.
- Assert rst_n low during WRITE of an INSERT -> wren=0 immediately, state IDLE, req_ready=1 after release, statistics 0.
